// File: rtl/fetch_dec_queue_pkg.sv
// fetch_dec_queue_pkg: shared widths, default depth and the packed IQ entry layout.
package fetch_dec_queue_pkg;
  localparam int PC_WIDTH = 39;
  localparam int EXCEPTION_CAUSE_WIDTH = 4;
  localparam int IQ_DEPTH = 8;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] predict_pc;
    logic [31:0] instr;
    logic is_rv;
    logic excp_vld;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] ecause;
  } iq_entry_t;
  localparam int ENTRY_WIDTH = $bits(iq_entry_t);
endpackage

// File: rtl/fetch_dec_queue_ptr_ctrl.sv
// iq_ptr_ctrl: head/tail/count bookkeeping for 2-wide push/pop with flush, plus ready generation.
module iq_ptr_ctrl #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush_i,
  input  logic          first_vld_i,
  input  logic          second_vld_i,
  input  logic          first_rdy_i,
  input  logic          second_rdy_i,
  output logic [PW-1:0] head_o,
  output logic [PW-1:0] tail_o,
  output logic [CW-1:0] count_o,
  output logic          push0_o,
  output logic          push1_o,
  output logic          single_rdy_o,
  output logic          double_rdy_o,
  output logic          first_vld_o,
  output logic          second_vld_o
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic pop0, pop1;
  // Ready looks only at the start-of-cycle count: a full queue never accepts, even while popping.
  assign single_rdy_o = (count_q <= CW'(DEPTH - 1)) & ~flush_i;
  assign double_rdy_o = (count_q <= CW'(DEPTH - 2)) & ~flush_i;
  assign first_vld_o  = count_q != '0;
  assign second_vld_o = count_q >= CW'(2);
  assign push0_o = first_vld_i & single_rdy_o;
  assign push1_o = second_vld_i & first_vld_i & double_rdy_o;
  assign pop0 = first_vld_o & first_rdy_i;
  assign pop1 = pop0 & second_vld_o & second_rdy_i;
  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  always_comb begin
    head_d  = flush_i ? '0 : head_q + PW'(pop0) + PW'(pop1);
    tail_d  = flush_i ? '0 : tail_q + PW'(push0_o) + PW'(push1_o);
    count_d = flush_i ? '0 : count_q + CW'(push0_o) + CW'(push1_o) - CW'(pop0) - CW'(pop1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fetch_dec_queue.sv
// fetch_dec_queue: dual-issue circular instruction queue between fetch and decode, flushed on redirect.
module fetch_dec_queue
  import fetch_dec_queue_pkg::*;
#(
  parameter int IQ_DEPTH = fetch_dec_queue_pkg::IQ_DEPTH,
  localparam int PW = $clog2(IQ_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush_i,
  input  logic                             if_first_vld_i,
  input  logic [PC_WIDTH-1:0]              if_first_pc_i,
  input  logic [PC_WIDTH-1:0]              if_first_next_pc_i,
  input  logic [PC_WIDTH-1:0]              if_first_predict_pc_i,
  input  logic [31:0]                      if_first_instr_i,
  input  logic                             if_first_is_rv_i,
  input  logic                             if_first_excp_vld_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] if_first_ecause_i,
  input  logic                             if_second_vld_i,
  input  logic [PC_WIDTH-1:0]              if_second_pc_i,
  input  logic [PC_WIDTH-1:0]              if_second_next_pc_i,
  input  logic [PC_WIDTH-1:0]              if_second_predict_pc_i,
  input  logic [31:0]                      if_second_instr_i,
  input  logic                             if_second_is_rv_i,
  input  logic                             if_second_excp_vld_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] if_second_ecause_i,
  output logic                             single_rdy_o,
  output logic                             double_rdy_o,
  output logic                             dec_first_vld_o,
  output logic [PC_WIDTH-1:0]              dec_first_pc_o,
  output logic [PC_WIDTH-1:0]              dec_first_next_pc_o,
  output logic [PC_WIDTH-1:0]              dec_first_predict_pc_o,
  output logic [31:0]                      dec_first_instr_o,
  output logic                             dec_first_is_rv_o,
  output logic                             dec_first_excp_vld_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] dec_first_ecause_o,
  output logic                             dec_second_vld_o,
  output logic [PC_WIDTH-1:0]              dec_second_pc_o,
  output logic [PC_WIDTH-1:0]              dec_second_next_pc_o,
  output logic [PC_WIDTH-1:0]              dec_second_predict_pc_o,
  output logic [31:0]                      dec_second_instr_o,
  output logic                             dec_second_is_rv_o,
  output logic                             dec_second_excp_vld_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] dec_second_ecause_o,
  input  logic                             dec_first_rdy_i,
  input  logic                             dec_second_rdy_i,
  output logic [CW-1:0]                    iq_count_o,
  output logic                             iq_empty_o
);
  logic [PW-1:0] head, tail;
  logic push0, push1;
  iq_entry_t in0, in1, out0, out1;
  iq_entry_t mem_q [IQ_DEPTH];
  iq_entry_t mem_d [IQ_DEPTH];
  iq_ptr_ctrl #(.DEPTH(IQ_DEPTH)) u_ptr (
    .clk          (clk),
    .rstn         (rstn),
    .flush_i      (flush_i),
    .first_vld_i  (if_first_vld_i),
    .second_vld_i (if_second_vld_i),
    .first_rdy_i  (dec_first_rdy_i),
    .second_rdy_i (dec_second_rdy_i),
    .head_o       (head),
    .tail_o       (tail),
    .count_o      (iq_count_o),
    .push0_o      (push0),
    .push1_o      (push1),
    .single_rdy_o (single_rdy_o),
    .double_rdy_o (double_rdy_o),
    .first_vld_o  (dec_first_vld_o),
    .second_vld_o (dec_second_vld_o)
  );
  assign iq_empty_o = iq_count_o == '0;
  assign in0 = {if_first_pc_i, if_first_next_pc_i, if_first_predict_pc_i, if_first_instr_i,
                if_first_is_rv_i, if_first_excp_vld_i, if_first_ecause_i};
  assign in1 = {if_second_pc_i, if_second_next_pc_i, if_second_predict_pc_i, if_second_instr_i,
                if_second_is_rv_i, if_second_excp_vld_i, if_second_ecause_i};
  always_comb begin
    mem_d = mem_q;
    if (push0) mem_d[tail] = in0;
    if (push1) mem_d[tail + PW'(1)] = in1;
  end
  // Storage is reset so the don't-care data outputs are never X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < IQ_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
  assign out0 = mem_q[head];
  assign out1 = mem_q[head + PW'(1)];
  assign {dec_first_pc_o, dec_first_next_pc_o, dec_first_predict_pc_o, dec_first_instr_o,
          dec_first_is_rv_o, dec_first_excp_vld_o, dec_first_ecause_o} = out0;
  assign {dec_second_pc_o, dec_second_next_pc_o, dec_second_predict_pc_o, dec_second_instr_o,
          dec_second_is_rv_o, dec_second_excp_vld_o, dec_second_ecause_o} = out1;
  a_second_needs_first: assert property (@(posedge clk) disable iff (!rstn)
    if_second_vld_i |-> if_first_vld_i);
endmodule

// File: tb/tb_fetch_dec_queue.sv
// tb_fetch_dec_queue: directed table, hand sequences and random traffic against a queue-based model.
module tb_fetch_dec_queue;
  import fetch_dec_queue_pkg::*;
  localparam int D = IQ_DEPTH;
  localparam int CW = $clog2(D) + 1;
  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic fv = 1'b0, sv = 1'b0, fr = 1'b0, sr = 1'b0;
  iq_entry_t in0 = '0, in1 = '0, out0, out1;
  logic srdy, drdy, v0, v1, empty;
  logic [CW-1:0] cnt;
  logic [PC_WIDTH-1:0] d0_pc, d0_npc, d0_ppc, d1_pc, d1_npc, d1_ppc;
  logic [31:0] d0_instr, d1_instr;
  logic d0_rv, d0_ex, d1_rv, d1_ex;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] d0_ec, d1_ec;
  int checks = 0, failures = 0;
  iq_entry_t q[$];
  typedef struct {
    logic fv, sv, fr, sr, fl;
    logic [PC_WIDTH-1:0] pa, pb;
    int cnt;
    logic srdy, drdy, v0, v1;
    logic [PC_WIDTH-1:0] h0, h1;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  assign out0 = {d0_pc, d0_npc, d0_ppc, d0_instr, d0_rv, d0_ex, d0_ec};
  assign out1 = {d1_pc, d1_npc, d1_ppc, d1_instr, d1_rv, d1_ex, d1_ec};

  fetch_dec_queue dut (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .if_first_vld_i(fv), .if_first_pc_i(in0.pc), .if_first_next_pc_i(in0.next_pc),
    .if_first_predict_pc_i(in0.predict_pc), .if_first_instr_i(in0.instr),
    .if_first_is_rv_i(in0.is_rv), .if_first_excp_vld_i(in0.excp_vld), .if_first_ecause_i(in0.ecause),
    .if_second_vld_i(sv), .if_second_pc_i(in1.pc), .if_second_next_pc_i(in1.next_pc),
    .if_second_predict_pc_i(in1.predict_pc), .if_second_instr_i(in1.instr),
    .if_second_is_rv_i(in1.is_rv), .if_second_excp_vld_i(in1.excp_vld), .if_second_ecause_i(in1.ecause),
    .single_rdy_o(srdy), .double_rdy_o(drdy),
    .dec_first_vld_o(v0), .dec_first_pc_o(d0_pc), .dec_first_next_pc_o(d0_npc),
    .dec_first_predict_pc_o(d0_ppc), .dec_first_instr_o(d0_instr), .dec_first_is_rv_o(d0_rv),
    .dec_first_excp_vld_o(d0_ex), .dec_first_ecause_o(d0_ec),
    .dec_second_vld_o(v1), .dec_second_pc_o(d1_pc), .dec_second_next_pc_o(d1_npc),
    .dec_second_predict_pc_o(d1_ppc), .dec_second_instr_o(d1_instr), .dec_second_is_rv_o(d1_rv),
    .dec_second_excp_vld_o(d1_ex), .dec_second_ecause_o(d1_ec),
    .dec_first_rdy_i(fr), .dec_second_rdy_i(sr),
    .iq_count_o(cnt), .iq_empty_o(empty)
  );

  function automatic iq_entry_t mk(input logic [PC_WIDTH-1:0] pc, input logic rv,
                                   input logic ex = 1'b0,
                                   input logic [EXCEPTION_CAUSE_WIDTH-1:0] ec = '0);
    iq_entry_t e;
    e.pc = pc;
    e.next_pc = pc + (rv ? 4 : 2);
    e.predict_pc = pc + 8;
    e.instr = {pc[29:0], 1'b1, rv};
    e.is_rv = rv;
    e.excp_vld = ex;
    e.ecause = ec;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_e(input string name, input iq_entry_t act, input iq_entry_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare pre-edge outputs with the model, then advance the model.
  task automatic step(input logic f_v, s_v, f_r, s_r, fl, input iq_entry_t e0, e1);
    int n;
    bit p0, p1, r0, r1;
    @(negedge clk);
    fv = f_v; sv = s_v; fr = f_r; sr = s_r; flush = fl; in0 = e0; in1 = e1;
    #1;
    n = q.size();
    chk("count", cnt, n);
    chk("empty", empty, n == 0);
    chk("single_rdy", srdy, n <= D - 1 && !fl);
    chk("double_rdy", drdy, n <= D - 2 && !fl);
    chk("first_vld", v0, n >= 1);
    chk("second_vld", v1, n >= 2);
    if (n >= 1) chk_e("first_entry", out0, q[0]);
    if (n >= 2) chk_e("second_entry", out1, q[1]);
    p0 = f_v && n < D && !fl;
    p1 = p0 && s_v && n <= D - 2;
    r0 = f_r && n >= 1;
    r1 = r0 && s_r && n >= 2;
    if (fl) q.delete();
    else begin
      if (r0) void'(q.pop_front());
      if (r1) void'(q.pop_front());
      if (p0) q.push_back(e0);
      if (p1) q.push_back(e1);
    end
  endtask

  task automatic idle(input logic f_r = 1'b0, input logic s_r = 1'b0);
    step(1'b0, 1'b0, f_r, s_r, 1'b0, '0, '0);
  endtask

  initial begin
    //         fv sv fr sr fl  pa      pb     cnt srdy drdy v0 v1  h0      h1
    tbl[0]  = '{1, 1, 0, 0, 0, 'h100, 'h104, 0, 1, 1, 0, 0, 'h0,   'h0};
    tbl[1]  = '{1, 1, 0, 0, 0, 'h108, 'h10c, 2, 1, 1, 1, 1, 'h100, 'h104};
    tbl[2]  = '{1, 1, 0, 0, 0, 'h110, 'h114, 4, 1, 1, 1, 1, 'h100, 'h104};
    tbl[3]  = '{1, 1, 0, 0, 0, 'h118, 'h11c, 6, 1, 1, 1, 1, 'h100, 'h104};
    tbl[4]  = '{0, 0, 0, 0, 0, 'h0,   'h0,   8, 0, 0, 1, 1, 'h100, 'h104};
    tbl[5]  = '{1, 1, 1, 0, 0, 'h200, 'h204, 8, 0, 0, 1, 1, 'h100, 'h104};
    tbl[6]  = '{0, 0, 0, 0, 0, 'h0,   'h0,   7, 1, 0, 1, 1, 'h104, 'h108};
    tbl[7]  = '{0, 0, 1, 1, 0, 'h0,   'h0,   7, 1, 0, 1, 1, 'h104, 'h108};
    tbl[8]  = '{1, 1, 1, 1, 1, 'h300, 'h304, 5, 0, 0, 1, 1, 'h10c, 'h110};
    tbl[9]  = '{1, 0, 0, 0, 0, 'h400, 'h0,   0, 1, 1, 0, 0, 'h0,   'h0};
    tbl[10] = '{0, 0, 0, 0, 0, 'h0,   'h0,   1, 1, 1, 1, 0, 'h400, 'h0};
    tbl[11] = '{0, 0, 1, 1, 0, 'h0,   'h0,   1, 1, 1, 1, 0, 'h400, 'h0};
    tbl[12] = '{0, 0, 0, 0, 0, 'h0,   'h0,   0, 1, 1, 0, 0, 'h0,   'h0};

    #1;
    chk("reset_count", cnt, 0);
    chk("reset_empty", empty, 1);
    chk("reset_first_vld", v0, 0);
    chk("reset_second_vld", v1, 0);
    #11 rstn = 1'b1;
    #1;
    chk("post_reset_single_rdy", srdy, 1);
    chk("post_reset_double_rdy", drdy, 1);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].fv, tbl[i].sv, tbl[i].fr, tbl[i].sr, tbl[i].fl,
           mk(tbl[i].pa, 1'b1), mk(tbl[i].pb, 1'b1));
      chk($sformatf("tbl%0d_count", i), cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_single_rdy", i), srdy, tbl[i].srdy);
      chk($sformatf("tbl%0d_double_rdy", i), drdy, tbl[i].drdy);
      chk($sformatf("tbl%0d_first_vld", i), v0, tbl[i].v0);
      chk($sformatf("tbl%0d_second_vld", i), v1, tbl[i].v1);
      if (tbl[i].v0) chk($sformatf("tbl%0d_first_pc", i), d0_pc, tbl[i].h0);
      if (tbl[i].v1) chk($sformatf("tbl%0d_second_pc", i), d1_pc, tbl[i].h1);
    end

    // Mixed rv/compressed preload, then dual retire.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk('h1000, 1'b1), mk('h1004, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk('h1006, 1'b1), '0);
    idle(1'b1, 1'b1);
    chk("pop2_first_pc", d0_pc, 'h1000);
    chk("pop2_second_pc", d1_pc, 'h1004);
    chk("pop2_second_is_rv", d1_rv, 0);
    idle(1'b1, 1'b1);
    chk("pop2_next_first_pc", d0_pc, 'h1006);
    chk("pop2_next_second_vld", v1, 0);

    // Exception entry passes through untouched.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk('h2000, 1'b1, 1'b1, 4'd12), '0);
    idle(1'b1, 1'b0);
    chk("excp_vld", d0_ex, 1);
    chk("excp_ecause", d0_ec, 12);
    chk("excp_pc", d0_pc, 'h2000);
    idle();

    // Random traffic, occasional flush; long enough to wrap the pointers many times.
    for (int c = 0; c < 400; c++) begin
      logic a, b;
      a = $urandom_range(0, 3) != 0;
      b = a & $urandom_range(0, 1);
      step(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
           mk(PC_WIDTH'({$urandom, $urandom}), 1'($urandom), 1'($urandom), 4'($urandom)),
           mk(PC_WIDTH'({$urandom, $urandom}), 1'($urandom), 1'($urandom), 4'($urandom)));
    end

    // Asynchronous reset mid-stream clears valids without a clock edge.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk('h3000, 1'b1), mk('h3004, 1'b0));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk('h3006, 1'b1), '0);
    @(negedge clk);
    fv = 1'b0; sv = 1'b0; fr = 1'b0; sr = 1'b0; flush = 1'b0;
    #1;
    chk("pre_arst_count", cnt, 3);
    #1 rstn = 1'b0;
    #1;
    chk("arst_first_vld", v0, 0);
    chk("arst_second_vld", v1, 0);
    chk("arst_count", cnt, 0);
    chk("arst_empty", empty, 1);
    q.delete();
    #1 rstn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk('h5000, 1'b0), '0);
    idle();
    chk("post_arst_first_pc", d0_pc, 'h5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_dec_queue.md
Name: fetch_dec_queue

Overview:
- Dual-issue instruction queue between the fetch stage and decode.
- Accepts 0/1/2 fetched instruction packets per cycle and returns single/double ready back to fetch.
- Presents up to 2 oldest entries to decode in program order; decode retires 0/1/2 per cycle.
- Flushed on global trap/ret/predict-miss so wrong-path instructions never reach decode.

Parameters:
- PC_WIDTH, 39, virtual PC width
- EXCEPTION_CAUSE_WIDTH, 4, ecause width
- IQ_DEPTH, 8, entries; power of two, >=4
- ENTRY_WIDTH, derived (3*PC_WIDTH+32+1+1+EXCEPTION_CAUSE_WIDTH), packed entry width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush_i  in  1  global_trap | global_ret | global_predict_miss
- if_first_vld_i  in  1  fetch slot0 valid
- if_first_pc_i / if_first_next_pc_i / if_first_predict_pc_i  in  PC_WIDTH each  slot0 pc fields
- if_first_instr_i  in  32  slot0 instruction
- if_first_is_rv_i  in  1  1=32-bit, 0=compressed
- if_first_excp_vld_i  in  1  slot0 fetch exception
- if_first_ecause_i  in  EXCEPTION_CAUSE_WIDTH  slot0 cause
- if_second_* (vld, pc, next_pc, predict_pc, instr, is_rv, excp_vld, ecause)  in  same widths  slot1 fields
- single_rdy_o  out  1  >=1 free entry
- double_rdy_o  out  1  >=2 free entries
- dec_first_vld_o / dec_second_vld_o  out  1  head / head+1 valid
- dec_first_* / dec_second_* (pc, next_pc, predict_pc, instr, is_rv, excp_vld, ecause)  out  as inputs  entry contents
- dec_first_rdy_i / dec_second_rdy_i  in  1  decode consumes slot
- iq_count_o  out  $clog2(IQ_DEPTH)+1  occupancy
- iq_empty_o  out  1  count==0

Behaviour:
- Storage: circular buffer of IQ_DEPTH entries; head/tail pointers $clog2(IQ_DEPTH) bits, wrap modulo IQ_DEPTH; count tracked separately.
- Ready: single_rdy_o=(count<=IQ_DEPTH-1) & ~flush_i; double_rdy_o=(count<=IQ_DEPTH-2) & ~flush_i. Both depend on start-of-cycle count only. No same-cycle dequeue credit, so a full queue never accepts even while popping.
- Enqueue:
  - push0 = if_first_vld_i & single_rdy_o.
  - push1 = if_second_vld_i & if_first_vld_i & double_rdy_o.
  - slot0 is written at tail, slot1 at tail+1; tail advances by push0+push1.
  - if_second_vld_i without if_first_vld_i is illegal; it is ignored and an assertion fires.
- Dequeue:
  - dec_first_vld_o = count>=1; dec_second_vld_o = count>=2.
  - pop0 = dec_first_vld_o & dec_first_rdy_i.
  - pop1 = pop0 & dec_second_vld_o & dec_second_rdy_i; slot1 never retires alone.
  - head advances by pop0+pop1.
- Outputs are driven combinationally from registered storage at head/head+1. There is no enq->deq bypass: an entry written in cycle N is visible to decode in N+1 at the earliest.
- Count: count_next = count + push0 + push1 - pop0 - pop1. Simultaneous push and pop are legal in any combination; count never exceeds IQ_DEPTH and never underflows.
- Flush: on flush_i, the next state is head=tail=count=0. Same-cycle pushes and pops are discarded, and ready is deasserted that cycle. Entry data is not cleared.
- Reset: async on rstn low. head=tail=count=0, so single_rdy_o=double_rdy_o=1 (after rstn high), dec_*_vld_o=0, iq_empty_o=1, iq_count_o=0.
- Data outputs when not valid are don't-care but must be X-free: storage is reset to 0.
- Exception entries are queued like normal entries, in order; the queue does not interpret them.

Decomposition:
- Shared package holds: the IQ entry struct/packed field offsets (pc, next_pc, predict_pc, instr, is_rv, excp_vld, ecause), PC_WIDTH, EXCEPTION_CAUSE_WIDTH and the IQ_DEPTH default.
- One natural sub-module, iq_ptr_ctrl: head/tail/count update for 2-wide push/pop plus flush, and ready generation.
- Storage and muxing stay in the top.

Test Plan:
- Reset then push 2/cycle with no pops, IQ_DEPTH=8 -> after 4 cycles count=8, single_rdy_o=0, double_rdy_o=0; at count=7, double_rdy_o=0 and single_rdy_o=1.
- Preload pc 0x1000,0x1004,0x1006, then pop with first_rdy=1, second_rdy=1 -> first cycle dec_first_pc=0x1000 and dec_second_pc=0x1004; next cycle dec_first_pc=0x1006 and dec_second_vld_o=0.
- count=8, push attempt plus pop 1 in the same cycle -> no write, count=7 next cycle.
- Wrap-around: 20 mixed push/pop cycles with rv/compressed entries -> output order exactly matches input order, and the head pointer wraps 7->0 correctly.
- Queue count=5 with push2 and flush_i in the same cycle -> next cycle count=0, iq_empty_o=1, dec_first_vld_o=0; a push the following cycle appears at the output one cycle later.
- Push entry with excp_vld=1, ecause=12 -> emitted intact with excp_vld=1, ecause=12; rstn asserted mid-stream -> all valids 0 immediately (asynchronous).
